atm_frame_fifo: RTL and testbench
=================================

ATM_FRAME_FIFO -- requirements
Module: atm_frame_fifo

Interface
REQ-001 SHALL have port SAMPLE_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port RST_sync  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port ENSAMP_sync  in  1  sampling enable; low blocks all writes.
REQ-004 SHALL have port DONE  in  1  one-cycle conversion-complete strobe from the ADC.
REQ-005 SHALL have port ADC_DATA  in  16  conversion result, valid when DONE=1.
REQ-006 SHALL have port ATMCHSEL_DATA  in  8  one-hot channel of the result, aligned with DONE.
REQ-007 SHALL have port LASTWORD  in  1  frame-end flag, aligned with DONE.
REQ-008 SHALL have port RD_EN  in  1  read request.
REQ-009 SHALL have port CLR_FLAGS  in  1  clears sticky flags.
REQ-010 SHALL have port RD_DATA  out  20  {lastword, ch[2:0], data[15:0]}.
REQ-011 SHALL have port RD_VALID  out  1  RD_DATA updated this cycle.
REQ-012 SHALL have port EMPTY, FULL  out  1 each  occupancy flags.
REQ-013 SHALL have port LEVEL  out  5  occupancy, 0..16.
REQ-014 SHALL have port OVF  out  1  sticky overflow.
REQ-015 SHALL have port CHERR  out  1  sticky invalid-channel error.
REQ-016 SHALL have port FRAME_CNT  out  8  completed frames written.

Function
REQ-017 SHALL store 20-bit entries in a 16-deep circular FIFO; pointers wrap 15->0.
REQ-018 SHALL convert ATMCHSEL_DATA to a 3-bit index for ch; bit n set -> ch=n.
REQ-019 SHALL treat a DONE with ATMCHSEL_DATA zero or multi-hot as invalid: no write, CHERR<=1, sync state unchanged.
REQ-020 SHALL run write-side FSM with states RUN and DROP.
REQ-021 In RUN, a valid DONE with space SHALL write {LASTWORD, ch, ADC_DATA}; the entry is visible in LEVEL next cycle.
REQ-022 Space SHALL exist when LEVEL<16, or LEVEL=16 with RD_EN=1 in the same cycle.
REQ-023 In RUN, a valid DONE without space SHALL discard the word and set OVF<=1.
REQ-024 On that overflow, the FSM SHALL stay in RUN if LASTWORD=1, else go to DROP.
REQ-025 In DROP, every DONE SHALL be discarded; DONE with LASTWORD=1 SHALL return to RUN next cycle.
REQ-026 With ENSAMP_sync=0, DONE SHALL be ignored and the FSM forced to RUN; FIFO contents are retained for readout.
REQ-027 RD_EN with LEVEL>0 SHALL load the head entry into RD_DATA next cycle, pulse RD_VALID for 1 cycle, and advance the read pointer.
REQ-028 RD_EN with LEVEL=0 SHALL be ignored, including when a write occurs in the same cycle (no bypass).
REQ-029 Simultaneous accepted read and write SHALL leave LEVEL unchanged.
REQ-030 EMPTY SHALL equal (LEVEL==0), FULL SHALL equal (LEVEL==16), and both SHALL be registered consistently with LEVEL.
REQ-031 FRAME_CNT SHALL increment by 1, modulo 256, on each accepted write with LASTWORD=1.
REQ-032 CLR_FLAGS SHALL clear OVF and CHERR next cycle.
REQ-033 A simultaneous CLR_FLAGS and new error event SHALL leave the flag set.
REQ-034 RD_DATA SHALL hold its value between reads.

Reset
REQ-035 RST_sync=1 SHALL on the next edge set pointers=0, LEVEL=0, EMPTY=1, FULL=0, RD_DATA=0, RD_VALID=0, OVF=0, CHERR=0, FRAME_CNT=0, FSM=RUN.
REQ-036 Reset SHALL override all other inputs, including a DONE or RD_EN in the same cycle.
REQ-037 Reset asserted mid-frame or mid-DROP SHALL discard all stored entries.

Verification
REQ-038 Channels 0,2,5 enabled, 2 frames of DONE, no reads -> LEVEL=6; reads return ch 0,2,5,0,2,5 with lastword=1 on ch5 entries; FRAME_CNT=2.
REQ-039 Fill to 16 with data entries, then DONE ch3 LASTWORD=0, then DONE ch7 LASTWORD=1, with space restored before the ch7 DONE -> OVF=1, neither word written, FSM returns to RUN, and the next DONE is written.
REQ-040 LEVEL=16 with RD_EN and DONE in the same cycle -> write accepted, LEVEL stays 16, OVF stays 0.
REQ-041 DONE with ATMCHSEL_DATA=8'h00 and another with 8'h03 -> no writes, CHERR=1; CLR_FLAGS -> CHERR=0.
REQ-042 RST_sync asserted with LEVEL=9 and FSM in DROP -> next cycle LEVEL=0, EMPTY=1, FSM=RUN, and all flags and counters 0.
REQ-043 LEVEL=0 with RD_EN and DONE in the same cycle -> no RD_VALID; LEVEL=1 next cycle.

Source files
------------

// File: rtl/atm_frame_fifo.sv
// atm_frame_fifo
//   16-deep, 20-bit circular FIFO that captures ADC conversion results.
//   Each DONE strobe carries a 16-bit result, a one-hot channel and a
//   frame-end flag. The stored entry is {lastword, ch[2:0], data[15:0]}.
//   A small write-side FSM discards the remainder of a frame once a word
//   of that frame has been lost to overflow.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   RUN   | accepting valid conversions into the FIFO
//   DROP  | overflow hit mid-frame; discard words until a frame-end word
//
// Ports
//   SAMPLE_CLK    in   sole clock, rising edge
//   RST_sync      in   synchronous active-high reset
//   ENSAMP_sync   in   sampling enable; low ignores DONE and forces RUN
//   DONE          in   one-cycle conversion-complete strobe
//   ADC_DATA      in   16-bit conversion result
//   ATMCHSEL_DATA in   one-hot channel select aligned with DONE
//   LASTWORD      in   frame-end flag aligned with DONE
//   RD_EN         in   read request
//   CLR_FLAGS     in   clears OVF and CHERR
//   RD_DATA       out  last entry read {lastword, ch, data}
//   RD_VALID      out  RD_DATA updated this cycle
//   EMPTY, FULL   out  registered occupancy flags
//   LEVEL         out  occupancy 0..16
//   OVF           out  sticky overflow
//   CHERR         out  sticky invalid-channel error
//   FRAME_CNT     out  completed frames written, modulo 256
module atm_frame_fifo (
  input  logic        SAMPLE_CLK,
  input  logic        RST_sync,
  input  logic        ENSAMP_sync,
  input  logic        DONE,
  input  logic [15:0] ADC_DATA,
  input  logic [7:0]  ATMCHSEL_DATA,
  input  logic        LASTWORD,
  input  logic        RD_EN,
  input  logic        CLR_FLAGS,
  output logic [19:0] RD_DATA,
  output logic        RD_VALID,
  output logic        EMPTY,
  output logic        FULL,
  output logic [4:0]  LEVEL,
  output logic        OVF,
  output logic        CHERR,
  output logic [7:0]  FRAME_CNT
);

  typedef enum logic {ST_RUN, ST_DROP} wr_state_t;

  wr_state_t   state;
  logic [19:0] mem [16];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic [2:0]  ch_idx;
  logic        ch_valid;
  logic        good_done;
  logic        bad_done;
  logic        has_space;
  logic        rd_accept;
  logic        wr_accept;
  logic        ovf_event;
  logic [4:0]  level_nxt;

  always_comb begin
    ch_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (ATMCHSEL_DATA[i]) ch_idx = i[2:0];
    end
  end

  assign ch_valid  = $onehot(ATMCHSEL_DATA);
  assign good_done = ENSAMP_sync && DONE && ch_valid;
  assign bad_done  = ENSAMP_sync && DONE && !ch_valid;
  assign rd_accept = RD_EN && (LEVEL != 5'd0);
  // When full, a read in the same cycle frees the head slot, so the write
  // may land there; the array read below still sees the old head value.
  assign has_space = !FULL || RD_EN;
  assign wr_accept = good_done && (state == ST_RUN) && has_space;
  assign ovf_event = good_done && (state == ST_RUN) && !has_space;

  always_comb begin
    level_nxt = LEVEL;
    case ({wr_accept, rd_accept})
      2'b10:   level_nxt = LEVEL + 5'd1;
      2'b01:   level_nxt = LEVEL - 5'd1;
      default: level_nxt = LEVEL;
    endcase
  end

  always_ff @(posedge SAMPLE_CLK) begin
    if (wr_accept && !RST_sync) begin
      mem[wr_ptr] <= {LASTWORD, ch_idx, ADC_DATA};
    end
  end

  always_ff @(posedge SAMPLE_CLK) begin
    if (RST_sync) begin
      state     <= ST_RUN;
      wr_ptr    <= 4'd0;
      rd_ptr    <= 4'd0;
      LEVEL     <= 5'd0;
      EMPTY     <= 1'b1;
      FULL      <= 1'b0;
      RD_DATA   <= 20'd0;
      RD_VALID  <= 1'b0;
      OVF       <= 1'b0;
      CHERR     <= 1'b0;
      FRAME_CNT <= 8'd0;
    end else begin
      LEVEL    <= level_nxt;
      EMPTY    <= (level_nxt == 5'd0);
      FULL     <= (level_nxt == 5'd16);
      RD_VALID <= rd_accept;

      if (wr_accept) begin
        wr_ptr <= wr_ptr + 4'd1;
        if (LASTWORD) FRAME_CNT <= FRAME_CNT + 8'd1;
      end

      if (rd_accept) begin
        RD_DATA <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 4'd1;
      end

      // A new error event wins over a simultaneous clear.
      if (ovf_event)      OVF <= 1'b1;
      else if (CLR_FLAGS) OVF <= 1'b0;

      if (bad_done)       CHERR <= 1'b1;
      else if (CLR_FLAGS) CHERR <= 1'b0;

      if (!ENSAMP_sync) begin
        state <= ST_RUN;
      end else begin
        case (state)
          ST_RUN:  if (ovf_event && !LASTWORD) state <= ST_DROP;
          ST_DROP: if (good_done && LASTWORD)  state <= ST_RUN;
          default: state <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_frame_fifo.sv
module tb_atm_frame_fifo;

  logic        SAMPLE_CLK = 1'b0;
  logic        RST_sync = 1'b1;
  logic        ENSAMP_sync = 1'b0;
  logic        DONE = 1'b0;
  logic [15:0] ADC_DATA = 16'd0;
  logic [7:0]  ATMCHSEL_DATA = 8'd0;
  logic        LASTWORD = 1'b0;
  logic        RD_EN = 1'b0;
  logic        CLR_FLAGS = 1'b0;
  logic [19:0] RD_DATA;
  logic        RD_VALID;
  logic        EMPTY;
  logic        FULL;
  logic [4:0]  LEVEL;
  logic        OVF;
  logic        CHERR;
  logic [7:0]  FRAME_CNT;

  int tests = 0;
  int fails = 0;
  logic [19:0] sb[$];

  atm_frame_fifo dut (
    .SAMPLE_CLK    (SAMPLE_CLK),
    .RST_sync      (RST_sync),
    .ENSAMP_sync   (ENSAMP_sync),
    .DONE          (DONE),
    .ADC_DATA      (ADC_DATA),
    .ATMCHSEL_DATA (ATMCHSEL_DATA),
    .LASTWORD      (LASTWORD),
    .RD_EN         (RD_EN),
    .CLR_FLAGS     (CLR_FLAGS),
    .RD_DATA       (RD_DATA),
    .RD_VALID      (RD_VALID),
    .EMPTY         (EMPTY),
    .FULL          (FULL),
    .LEVEL         (LEVEL),
    .OVF           (OVF),
    .CHERR         (CHERR),
    .FRAME_CNT     (FRAME_CNT)
  );

  always #5 SAMPLE_CLK = ~SAMPLE_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every RD_VALID pulse must match the oldest expected entry.
  always @(negedge SAMPLE_CLK) begin
    if (RD_VALID) begin
      if (sb.size() == 0) begin
        chk("unexpected_rd_valid", {12'd0, RD_DATA}, 32'hFFFFFFFF);
      end else begin
        chk("rd_data", {12'd0, RD_DATA}, {12'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge SAMPLE_CLK);
    #1;
  endtask

  task automatic done_op(input logic [7:0] oh, input logic [15:0] d, input logic last);
    ATMCHSEL_DATA = oh;
    ADC_DATA      = d;
    LASTWORD      = last;
    DONE          = 1'b1;
    tick();
    DONE          = 1'b0;
  endtask

  task automatic rd_op();
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
  endtask

  initial begin
    // Reset overrides a DONE and RD_EN in the same cycle.
    DONE = 1'b1; RD_EN = 1'b1; ENSAMP_sync = 1'b1; ATMCHSEL_DATA = 8'h01;
    tick(); tick();
    RST_sync = 1'b0; DONE = 1'b0; RD_EN = 1'b0;
    chk("rst_level", LEVEL, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_rd_valid", RD_VALID, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_cherr", CHERR, 0);
    chk("rst_frame_cnt", FRAME_CNT, 0);

    // Two frames on channels 0, 2, 5.
    done_op(8'h01, 16'h1111, 1'b0); sb.push_back(20'h01111);
    chk("first_write_level", LEVEL, 1);
    done_op(8'h04, 16'h2222, 1'b0); sb.push_back(20'h22222);
    done_op(8'h20, 16'h5555, 1'b1); sb.push_back(20'hD5555);
    done_op(8'h01, 16'hA001, 1'b0); sb.push_back(20'h0A001);
    done_op(8'h04, 16'hA002, 1'b0); sb.push_back(20'h2A002);
    done_op(8'h20, 16'hA005, 1'b1); sb.push_back(20'hDA005);
    chk("two_frames_level", LEVEL, 6);
    chk("two_frames_cnt", FRAME_CNT, 2);
    for (int i = 0; i < 6; i++) rd_op();
    tick();
    chk("drain_level", LEVEL, 0);
    chk("drain_empty", EMPTY, 1);

    // Invalid channel selects.
    done_op(8'h00, 16'hDEAD, 1'b1);
    done_op(8'h03, 16'hBEEF, 1'b1);
    chk("cherr_level", LEVEL, 0);
    chk("cherr_set", CHERR, 1);
    chk("cherr_no_frame", FRAME_CNT, 2);
    CLR_FLAGS = 1'b1; tick(); CLR_FLAGS = 1'b0;
    chk("cherr_clr", CHERR, 0);
    CLR_FLAGS = 1'b1; done_op(8'h81, 16'h0000, 1'b0); CLR_FLAGS = 1'b0;
    chk("cherr_clr_race", CHERR, 1);
    CLR_FLAGS = 1'b1; tick(); CLR_FLAGS = 1'b0;

    // Fill, overflow mid-frame, recover at frame end.
    for (int i = 1; i <= 16; i++) begin
      done_op(8'h02, 16'h3000 + 16'(i), 1'b0);
      sb.push_back(20'h13000 + 20'(i));
    end
    chk("fill_level", LEVEL, 16);
    chk("fill_full", FULL, 1);
    chk("fill_empty", EMPTY, 0);
    done_op(8'h08, 16'h3333, 1'b0);
    chk("ovf_set", OVF, 1);
    chk("ovf_level", LEVEL, 16);
    rd_op();
    chk("ovf_read_level", LEVEL, 15);
    done_op(8'h80, 16'h7777, 1'b1);
    chk("drop_discard_level", LEVEL, 15);
    chk("drop_no_frame", FRAME_CNT, 2);
    done_op(8'h10, 16'h4444, 1'b1); sb.push_back(20'hC4444);
    chk("recover_level", LEVEL, 16);
    chk("recover_frame", FRAME_CNT, 3);
    CLR_FLAGS = 1'b1; tick(); CLR_FLAGS = 1'b0;
    chk("ovf_clr", OVF, 0);

    // Full with simultaneous read and write.
    RD_EN = 1'b1; done_op(8'h40, 16'h6666, 1'b0); RD_EN = 1'b0;
    sb.push_back(20'h66666);
    chk("rw_full_level", LEVEL, 16);
    chk("rw_full_ovf", OVF, 0);
    for (int i = 0; i < 16; i++) rd_op();
    tick();
    chk("drain2_level", LEVEL, 0);

    // Empty with simultaneous read and write: no bypass.
    RD_EN = 1'b1; done_op(8'h08, 16'h7777, 1'b1); RD_EN = 1'b0;
    sb.push_back(20'hB7777);
    chk("no_bypass_valid", RD_VALID, 0);
    chk("no_bypass_level", LEVEL, 1);
    rd_op();
    tick(); tick();
    chk("rd_data_hold", RD_DATA, 20'hB7777);

    // Reach DROP with LEVEL=9, then reset.
    for (int i = 0; i < 16; i++) begin
      done_op(8'h80, 16'h8000 + 16'(i), 1'b0);
      sb.push_back(20'h78000 + 20'(i));
    end
    done_op(8'h02, 16'h1234, 1'b0);
    for (int i = 0; i < 7; i++) rd_op();
    done_op(8'h04, 16'h5678, 1'b0);
    chk("drop9_level", LEVEL, 9);
    tick();
    RST_sync = 1'b1; RD_EN = 1'b1; done_op(8'h01, 16'h9999, 1'b1);
    RST_sync = 1'b0; RD_EN = 1'b0;
    sb.delete();
    chk("rst2_level", LEVEL, 0);
    chk("rst2_empty", EMPTY, 1);
    chk("rst2_ovf", OVF, 0);
    chk("rst2_frame", FRAME_CNT, 0);
    chk("rst2_rd_valid", RD_VALID, 0);

    // Sampling disabled ignores DONE.
    ENSAMP_sync = 1'b0;
    done_op(8'h01, 16'hAAAA, 1'b1);
    chk("ensamp_off_level", LEVEL, 0);
    ENSAMP_sync = 1'b1;

    // DROP is forced back to RUN by a sampling-disable cycle.
    for (int i = 0; i < 16; i++) begin
      done_op(8'h20, 16'h9000 + 16'(i), 1'b0);
      sb.push_back(20'h59000 + 20'(i));
    end
    done_op(8'h01, 16'h0BAD, 1'b0);
    chk("ovf2_set", OVF, 1);
    ENSAMP_sync = 1'b0; tick(); ENSAMP_sync = 1'b1;
    rd_op();
    done_op(8'h02, 16'hBEEF, 1'b1); sb.push_back(20'h9BEEF);
    chk("forced_run_level", LEVEL, 16);
    chk("forced_run_frame", FRAME_CNT, 1);
    for (int i = 0; i < 16; i++) rd_op();
    tick(); tick();
    chk("final_level", LEVEL, 0);
    chk("final_rd_data", RD_DATA, 20'h9BEEF);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
